i2c_scl_gen: RTL and testbench
==============================

I2C_SCL_GEN -- requirements
Module: i2c_scl_gen

Interface
REQ-001 Parameter DIVIDER, default 7000: clk cycles per SCL quarter-period; legal range is 2 or more.
REQ-002 Parameter TIMEOUT, default 65535: maximum stretch length in clk cycles before abort; legal range is 1 or more.
REQ-003 Parameter CNT_W, default $clog2(DIVIDER): width of the quarter counter.
REQ-004 Parameter TO_W, default $clog2(TIMEOUT+1): width of the stretch counter.
REQ-005 clk  input  1  system clock; all logic is on posedge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  run SCL generation; 0 parks the block in IDLE at the end of the current period.
REQ-008 scl_not_ena  input  1  1 means the master does not own the clock, so stretch detection is disabled.
REQ-009 scl_in  input  1  synchronised sensed SCL bus level.
REQ-010 scl_oe  output  1  1 drives SCL low; 0 releases SCL.
REQ-011 data_clk  output  1  SDA update/sample clock; high in Q1 and Q2.
REQ-012 data_rise  output  1  one-cycle pulse on the first clk of Q1.
REQ-013 switch_range  output  1  high while in Q2 or STRETCH.
REQ-014 stretching  output  1  high while in STRETCH.
REQ-015 timeout  output  1  one-cycle pulse when a stretch exceeds TIMEOUT.

Function
REQ-016 The block SHALL be an FSM with states IDLE, Q0, Q1, Q2, Q3, STRETCH, plus a quarter counter qcnt[CNT_W] and a stretch counter tcnt[TO_W].
REQ-017 IDLE: scl_oe=0, data_clk=0, qcnt=0; the FSM SHALL move to Q0 on the first clk with en=1.
REQ-018 Each of Q0 to Q3 SHALL last exactly DIVIDER clks; qcnt counts 0..DIVIDER-1, and the state advances with qcnt wrapping to 0 on qcnt==DIVIDER-1.
REQ-019 Output levels per state SHALL be: Q0 scl_oe=1, data_clk=0; Q1 scl_oe=1, data_clk=1; Q2 scl_oe=0, data_clk=1; Q3 scl_oe=0, data_clk=0.
REQ-020 On the first clk of Q2 (qcnt==0), if scl_in==0 and scl_not_ena==0, the FSM SHALL enter STRETCH and qcnt SHALL hold at 0.
REQ-021 STRETCH SHALL keep scl_oe=0 and data_clk=1, and SHALL increment tcnt each clk.
REQ-022 STRETCH SHALL return to Q2 with qcnt=0 and tcnt=0 on the clk where scl_in==1; Q2 then runs its full DIVIDER clks.
REQ-023 In STRETCH, if tcnt reaches TIMEOUT while scl_in==0, the block SHALL pulse timeout for 1 clk, clear tcnt, and go to IDLE.
REQ-024 If scl_in==1 on the same clk that tcnt reaches TIMEOUT, release SHALL win: no timeout pulse, and the FSM goes to Q2.
REQ-025 scl_not_ena==1, or scl_in==1 at Q2 entry, SHALL produce no stretch; Q2 lasts DIVIDER clks.
REQ-026 At the end of Q3, the FSM SHALL go to Q0 if en==1, else to IDLE; deasserting en mid-period SHALL NOT truncate the period.
REQ-027 The full period without stretch SHALL be exactly 4*DIVIDER clks; periods are back-to-back with no idle cycle.
REQ-028 Counters SHALL never exceed their terminal values; qcnt and tcnt compares SHALL be width-safe for DIVIDER and TIMEOUT equal to a power of 2.
REQ-029 All outputs SHALL be registered, with no combinational path from scl_in to any output.

Reset
REQ-030 rst SHALL force state=IDLE, qcnt=0, tcnt=0, scl_oe=0, data_clk=0, data_rise=0, switch_range=0, stretching=0, timeout=0 on the next clk edge.
REQ-031 rst SHALL take priority over every other input, including mid-STRETCH; no timeout pulse is issued on reset.
REQ-032 The block SHALL leave reset only into IDLE, with Q0 beginning no earlier than the clk after rst deasserts with en=1.

Structure
REQ-033 The state enum (i2c_phase_t) and the default DIVIDER and TIMEOUT constants SHALL live in package i2c_pkg, shared with the future byte engine.
REQ-034 The block SHALL be a single module with no sub-module; scl_in synchronisation is done by the instantiating level.
REQ-035 The design SHALL carry assertions for: stretching implies scl_oe==0; timeout is one cycle only; and liveness, i.e. with en high and scl_in eventually high, the FSM eventually leaves STRETCH.

Verification (DIVIDER=4, TIMEOUT=10)
REQ-036 Free run: rst then en=1, scl_in follows ~scl_oe -> scl_oe pattern 1x8 then 0x8, period 16 clks, data_rise every 16 clks.
REQ-037 Stretch: scl_in held 0 for 6 clks after Q2 entry -> stretching high 6 clks, then Q2 lasts 4 clks, period 22 clks.
REQ-038 Timeout: scl_in stuck 0 -> timeout pulses exactly once at the 10th STRETCH clk, state=IDLE, scl_oe=0.
REQ-039 Release/timeout tie: scl_in rises on the clk tcnt hits 10 -> no timeout pulse, Q2 resumes.
REQ-040 scl_not_ena=1 with scl_in stuck 0 -> no stretch, period 16 clks.
REQ-041 rst asserted mid-STRETCH -> all outputs 0 next clk; en dropped in Q1 -> current period completes, then IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: SCL phase encoding and default timing constants.
// Used by the SCL generator and the byte engine.
package i2c_pkg;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_Q0,
    PH_Q1,
    PH_Q2,
    PH_Q3,
    PH_STRETCH
  } i2c_phase_t;

  localparam int I2C_DIVIDER = 7000;
  localparam int I2C_TIMEOUT = 65535;

endpackage

// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: four-quarter SCL with slave clock-stretch detection
// and stretch timeout.
// Ports: clk, rst (sync, active-high), en, scl_not_ena, scl_in (synchronised)
//   -> scl_oe, data_clk, data_rise, switch_range, stretching, timeout.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int DIVIDER = I2C_DIVIDER,
  parameter int TIMEOUT = I2C_TIMEOUT,
  parameter int CNT_W   = $clog2(DIVIDER),
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic scl_not_ena,
  input  logic scl_in,
  output logic scl_oe,
  output logic data_clk,
  output logic data_rise,
  output logic switch_range,
  output logic stretching,
  output logic timeout
);

  // Terminal values sized to the counter widths so the compares stay
  // correct when DIVIDER or TIMEOUT is a power of two.
  localparam logic [CNT_W-1:0] QLAST = CNT_W'(DIVIDER - 1);
  localparam logic [TO_W-1:0]  TLAST = TO_W'(TIMEOUT - 1);

  i2c_phase_t       state_q, state_d;
  logic [CNT_W-1:0] qcnt_q, qcnt_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic             to_d;

  logic scl_oe_q, scl_oe_d;
  logic dclk_q, dclk_d;
  logic rise_q, rise_d;
  logic sw_q, sw_d;
  logic str_q, str_d;
  logic to_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PH_IDLE;
      qcnt_q   <= '0;
      tcnt_q   <= '0;
      scl_oe_q <= 1'b0;
      dclk_q   <= 1'b0;
      rise_q   <= 1'b0;
      sw_q     <= 1'b0;
      str_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      tcnt_q   <= tcnt_d;
      scl_oe_q <= scl_oe_d;
      dclk_q   <= dclk_d;
      rise_q   <= rise_d;
      sw_q     <= sw_d;
      str_q    <= str_d;
      to_q     <= to_d;
    end
  end

  logic q_end;
  assign q_end = (qcnt_q == QLAST);

  always_comb begin
    state_d = state_q;
    qcnt_d  = q_end ? '0 : qcnt_q + CNT_W'(1);
    tcnt_d  = '0;
    to_d    = 1'b0;
    unique case (state_q)
      PH_IDLE: begin
        qcnt_d = '0;
        if (en) state_d = PH_Q0;
      end
      PH_Q0: if (q_end) state_d = PH_Q1;
      PH_Q1: if (q_end) state_d = PH_Q2;
      PH_Q2: begin
        // Slave holding SCL low as we release it: stretch, qcnt parked.
        if (qcnt_q == '0 && !scl_in && !scl_not_ena) begin
          state_d = PH_STRETCH;
          qcnt_d  = '0;
        end else if (q_end) begin
          state_d = PH_Q3;
        end
      end
      PH_Q3: if (q_end) state_d = en ? PH_Q0 : PH_IDLE;
      PH_STRETCH: begin
        qcnt_d = '0;
        // Release wins over a simultaneous timeout.
        if (scl_in) begin
          state_d = PH_Q2;
        end else if (tcnt_q == TLAST) begin
          state_d = PH_IDLE;
          to_d    = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = PH_IDLE;
        qcnt_d  = '0;
      end
    endcase
  end

  // Outputs decoded from the next state and registered, so they line up
  // with state_q and have no path from scl_in.
  always_comb begin
    scl_oe_d = 1'b0;
    dclk_d   = 1'b0;
    rise_d   = 1'b0;
    sw_d     = 1'b0;
    str_d    = 1'b0;
    unique case (state_d)
      PH_IDLE: ;
      PH_Q0: scl_oe_d = 1'b1;
      PH_Q1: begin
        scl_oe_d = 1'b1;
        dclk_d   = 1'b1;
        rise_d   = (qcnt_d == '0);
      end
      PH_Q2: begin
        dclk_d = 1'b1;
        sw_d   = 1'b1;
      end
      PH_Q3: ;
      PH_STRETCH: begin
        dclk_d = 1'b1;
        sw_d   = 1'b1;
        str_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign scl_oe       = scl_oe_q;
  assign data_clk     = dclk_q;
  assign data_rise    = rise_q;
  assign switch_range = sw_q;
  assign stretching   = str_q;
  assign timeout      = to_q;

  a_str_rel: assert property (@(posedge clk) disable iff (rst)
    stretching |-> !scl_oe);
  a_to_one: assert property (@(posedge clk) disable iff (rst)
    timeout |=> !timeout);
  a_live: assert property (@(posedge clk) disable iff (rst)
    (state_q == PH_STRETCH && en && scl_in) |=> state_q != PH_STRETCH);

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed bench for i2c_scl_gen with DIVIDER=4, TIMEOUT=10.
// Bus modelled as wired-AND of master drive and a slave hold.
module tb_i2c_scl_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic scl_not_ena = 1'b0;
  logic hold = 1'b0;
  logic scl_in;
  logic scl_oe, data_clk, data_rise, switch_range, stretching, timeout;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign scl_in = ~scl_oe & ~hold;

  i2c_scl_gen #(.DIVIDER(4), .TIMEOUT(10)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .scl_not_ena(scl_not_ena),
    .scl_in(scl_in),
    .scl_oe(scl_oe),
    .data_clk(data_clk),
    .data_rise(data_rise),
    .switch_range(switch_range),
    .stretching(stretching),
    .timeout(timeout)
  );

  function automatic logic [5:0] outs();
    return {scl_oe, data_clk, data_rise, switch_range, stretching, timeout};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    @(negedge clk);
    total++;
    if (outs() !== 6'b0) begin
      bad++;
      $display("FAIL reset outs got=%b exp=%b", outs(), 6'b0);
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  // Cycle 0 of each loop below is the first cycle of Q0.
  task automatic test_free_run();
    logic [5:0] exp;
    int m;
    rst = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      m = i % 16;
      exp = {m < 8, m >= 4 && m < 12, m == 4, m >= 8 && m < 12, 1'b0, 1'b0};
      total++;
      if (outs() !== exp) begin
        bad++;
        $display("FAIL free_run cyc=%0d got=%b exp=%b", i, outs(), exp);
      end
    end
  endtask

  task automatic test_stretch();
    int n_str = 0;
    int n_sw = 0;
    int n_rise = 0;
    for (int j = 0; j < 23; j++) begin
      @(negedge clk);
      hold = (j >= 8 && j <= 13);
      if (stretching) n_str++;
      if (switch_range) n_sw++;
      if (data_rise) n_rise++;
      if (stretching && scl_oe) begin
        total++;
        bad++;
        $display("FAIL stretch_oe cyc=%0d got=1 exp=0", j);
      end
    end
    hold = 1'b0;
    total++;
    if (n_str !== 6) begin
      bad++;
      $display("FAIL stretch_len got=%0d exp=6", n_str);
    end
    // Q2 first clk + 6 stretch + full 4-clk Q2 after release.
    total++;
    if (n_sw !== 11) begin
      bad++;
      $display("FAIL stretch_q2 got=%0d exp=11", n_sw);
    end
    total++;
    if (n_rise !== 1) begin
      bad++;
      $display("FAIL stretch_rise got=%0d exp=1", n_rise);
    end
    @(negedge clk);
    total++;
    if (scl_oe !== 1'b1 || data_rise !== 1'b0) begin
      bad++;
      $display("FAIL stretch_next got=%b%b exp=10", scl_oe, data_rise);
    end
    // Realign to end of this Q0 cycle 0; finish the period before returning.
    for (int j = 1; j < 16; j++) @(negedge clk);
  endtask

  task automatic test_tie();
    int n_str = 0;
    int n_to = 0;
    for (int j = 0; j < 27; j++) begin
      @(negedge clk);
      hold = (j >= 8 && j <= 17);
      if (stretching) n_str++;
      if (timeout) n_to++;
      if (j == 19) begin
        total++;
        if ({switch_range, stretching, scl_oe} !== 3'b100) begin
          bad++;
          $display("FAIL tie_q2 got=%b exp=100",
                   {switch_range, stretching, scl_oe});
        end
      end
    end
    hold = 1'b0;
    total++;
    if (n_str !== 10) begin
      bad++;
      $display("FAIL tie_len got=%0d exp=10", n_str);
    end
    total++;
    if (n_to !== 0) begin
      bad++;
      $display("FAIL tie_timeout got=%0d exp=0", n_to);
    end
  endtask

  task automatic test_timeout();
    int n_str = 0;
    int n_to = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      hold = (j >= 8);
      if (stretching) n_str++;
      if (timeout) n_to++;
      if (j == 18) begin
        total++;
        if (timeout !== 1'b0 || stretching !== 1'b1) begin
          bad++;
          $display("FAIL to_early got=%b%b exp=01", timeout, stretching);
        end
      end
    end
    total++;
    if (outs() !== 6'b000001) begin
      bad++;
      $display("FAIL to_idle got=%b exp=%b", outs(), 6'b000001);
    end
    total++;
    if (n_str !== 10 || n_to !== 1) begin
      bad++;
      $display("FAIL to_count got=%0d/%0d exp=10/1", n_str, n_to);
    end
    scl_not_ena = 1'b1;
    @(negedge clk);
    total++;
    if (timeout !== 1'b0 || scl_oe !== 1'b1) begin
      bad++;
      $display("FAIL to_after got=%b%b exp=01", timeout, scl_oe);
    end
  endtask

  task automatic test_not_ena();
    int n_str = 0;
    // Already observed cycle 0 of Q0 above.
    for (int j = 1; j < 17; j++) begin
      @(negedge clk);
      if (stretching) n_str++;
      if (j < 16) begin
        total++;
        if (scl_oe !== (j < 8)) begin
          bad++;
          $display("FAIL not_ena cyc=%0d got=%b exp=%b", j, scl_oe, j < 8);
        end
      end
    end
    total++;
    if (n_str !== 0 || scl_oe !== 1'b1 || data_clk !== 1'b0) begin
      bad++;
      $display("FAIL not_ena_end got=%0d%b%b exp=010", n_str, scl_oe,
               data_clk);
    end
    hold = 1'b0;
    scl_not_ena = 1'b0;
  endtask

  task automatic test_en_drop();
    logic [5:0] exp;
    for (int j = 1; j < 20; j++) begin
      @(negedge clk);
      if (j == 5) en = 1'b0;
      if (j < 16)
        exp = {j < 8, j >= 4 && j < 12, j == 4, j >= 8 && j < 12, 2'b00};
      else
        exp = 6'b0;
      total++;
      if (outs() !== exp) begin
        bad++;
        $display("FAIL en_drop cyc=%0d got=%b exp=%b", j, outs(), exp);
      end
    end
  endtask

  task automatic test_rst_stretch();
    en = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      hold = (j >= 8);
      if (j == 11) rst = 1'b1;
    end
    @(negedge clk);
    total++;
    if (outs() !== 6'b0) begin
      bad++;
      $display("FAIL rst_stretch got=%b exp=%b", outs(), 6'b0);
    end
    en = 1'b0;
    hold = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (timeout) begin
        total++;
        bad++;
        $display("FAIL rst_to cyc=%0d got=1 exp=0", j);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (outs() !== 6'b0) begin
      bad++;
      $display("FAIL rst_idle got=%b exp=%b", outs(), 6'b0);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stretch();
    test_tie();
    test_timeout();
    test_not_ena();
    test_en_drop();
    test_rst_stretch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
